// File: rtl/nx_mem_typePKG.sv
// Shared types for the indirect-access memory arbiter.
// Holds the arbiter FSM state, starve counter type and defaults.
package nx_mem_typePKG;

  typedef enum logic {
    HW_SLOT = 1'b0,
    SW_HOLD = 1'b1
  } arb_st_e;

  localparam int unsigned STARVE_LIMIT_DEF = 7;
  localparam int unsigned SCNT_W = 3;

  typedef logic [SCNT_W-1:0] scnt_t;

  function automatic scnt_t sat_inc(input scnt_t v);
    return (&v) ? v : v + scnt_t'(1);
  endfunction

endpackage

// File: rtl/nx_rr_arb.sv
// Round-robin selector over N requesters.
// Ports: en_i gate, req_i, one-hot gnt_o, granted index idx_o.
module nx_rr_arb #(
  parameter int unsigned N = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o
);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  hi_req;
  logic [N-1:0]  src;
  logic [N-1:0]  pick;

  // Prefer requesters at or above the pointer; otherwise wrap
  // to the lowest set bit. x & -x isolates the lowest one.
  always_comb begin
    hi_mask = ~((N'(1) << ptr_q) - N'(1));
    hi_req  = req_i & hi_mask;
    src     = (|hi_req) ? hi_req : req_i;
    pick    = src & (~src + N'(1));
    gnt_o   = en_i ? pick : '0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) idx_o = PW'(i);
    end
    ptr_d = ptr_q;
    if (|gnt_o) begin
      ptr_d = (idx_o == PW'(N - 1)) ? '0
                                    : idx_o + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/nx_ia_mem_arb.sv
// Arbiter sharing one table port between HW requesters and SW.
// Ports: hw_* datapath side, sw_*/grant/yield indirect side, mem_*.
module nx_ia_mem_arb
  import nx_mem_typePKG::*;
#(
  parameter int unsigned N_HW         = 2,
  parameter int unsigned N_ADDR_BITS  = 5,
  parameter int unsigned N_DATA_BITS  = 64,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_HW-1:0]                      hw_req,
  input  logic [N_HW-1:0]                      hw_we,
  input  logic [N_HW-1:0][N_ADDR_BITS-1:0]     hw_addr,
  input  logic [N_HW-1:0][N_DATA_BITS-1:0]     hw_wdat,
  output logic [N_HW-1:0]                      hw_gnt,
  output logic [N_HW-1:0]                      hw_rvld,
  output logic [N_DATA_BITS-1:0]               hw_rdat,
  input  logic                                 sw_cs,
  input  logic                                 sw_ce,
  input  logic                                 sw_we,
  input  logic [N_ADDR_BITS-1:0]               sw_add,
  input  logic [N_DATA_BITS-1:0]               sw_wdat,
  output logic [N_DATA_BITS-1:0]               sw_rdat,
  output logic                                 grant,
  input  logic                                 yield,
  output logic                                 mem_cs,
  output logic                                 mem_ce,
  output logic                                 mem_we,
  output logic [N_ADDR_BITS-1:0]               mem_add,
  output logic [N_DATA_BITS-1:0]               mem_wdat,
  input  logic [N_DATA_BITS-1:0]               mem_rdat
);

  localparam int unsigned PW = (N_HW > 1) ? $clog2(N_HW) : 1;

  arb_st_e         st_q, st_d;
  scnt_t           scnt_q, scnt_d;
  logic            done_q, done_d;
  logic [N_HW-1:0] rvld_q, rvld_d;

  logic            sw_slot;
  logic            sw_req;
  logic            sw_force;
  logic            sw_gnt;
  logic            hw_en;
  logic [N_HW-1:0] hw_gnt_w;
  logic [PW-1:0]   hw_idx;

  // done_q marks that this sw_cs episode was already served,
  // so a held chip select neither re-issues nor starves.
  always_comb begin
    sw_req   = sw_cs & ~done_q;
    sw_force = yield | (scnt_q == scnt_t'(STARVE_LIMIT));
    sw_gnt   = rst_n & sw_slot & sw_req
             & (sw_force | ~(|hw_req));
    hw_en    = rst_n & ~sw_gnt;
  end

  nx_rr_arb #(
    .N (N_HW)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (hw_en),
    .req_i (hw_req),
    .gnt_o (hw_gnt_w),
    .idx_o (hw_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= HW_SLOT;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      HW_SLOT: if (sw_gnt) st_d = SW_HOLD;
      SW_HOLD: st_d = HW_SLOT;
      default: st_d = HW_SLOT;
    endcase
  end

  always_comb begin
    sw_slot = 1'b0;
    unique case (st_q)
      HW_SLOT: sw_slot = 1'b1;
      SW_HOLD: sw_slot = 1'b0;
      default: sw_slot = 1'b0;
    endcase
  end

  always_comb begin
    scnt_d = (sw_req & ~sw_gnt) ? sat_inc(scnt_q) : '0;
    done_d = sw_cs & (done_q | sw_gnt);
    rvld_d = hw_gnt_w & ~hw_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_q <= '0;
      done_q <= 1'b0;
      rvld_q <= '0;
    end else begin
      scnt_q <= scnt_d;
      done_q <= done_d;
      rvld_q <= rvld_d;
    end
  end

  always_comb begin
    mem_cs   = 1'b0;
    mem_ce   = 1'b0;
    mem_we   = 1'b0;
    mem_add  = '0;
    mem_wdat = '0;
    unique case (1'b1)
      sw_gnt: begin
        mem_cs   = 1'b1;
        mem_ce   = sw_ce;
        mem_we   = sw_we;
        mem_add  = sw_add;
        mem_wdat = sw_wdat;
      end
      (|hw_gnt_w): begin
        mem_cs   = 1'b1;
        mem_we   = hw_we[hw_idx];
        mem_add  = hw_addr[hw_idx];
        mem_wdat = hw_wdat[hw_idx];
      end
      default: ;
    endcase
  end

  assign grant   = sw_gnt;
  assign hw_gnt  = hw_gnt_w;
  assign hw_rvld = rvld_q;
  assign hw_rdat = mem_rdat;
  assign sw_rdat = mem_rdat;

endmodule

// File: tb/tb_nx_ia_mem_arb.sv
// Randomized bench for nx_ia_mem_arb with a behavioural model.
// Directed scenarios pin the model with literal expectations.
module tb_nx_ia_mem_arb;

  localparam int N   = 2;
  localparam int LIM = 7;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       hw_req, hw_we;
  logic [1:0][4:0]  hw_addr;
  logic [1:0][63:0] hw_wdat;
  logic [1:0]       hw_gnt, hw_rvld;
  logic [63:0]      hw_rdat;
  logic             sw_cs, sw_ce, sw_we;
  logic [4:0]       sw_add;
  logic [63:0]      sw_wdat, sw_rdat;
  logic             grant, yield;
  logic             mem_cs, mem_ce, mem_we;
  logic [4:0]       mem_add;
  logic [63:0]      mem_wdat, mem_rdat;

  nx_ia_mem_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hw_req   (hw_req),
    .hw_we    (hw_we),
    .hw_addr  (hw_addr),
    .hw_wdat  (hw_wdat),
    .hw_gnt   (hw_gnt),
    .hw_rvld  (hw_rvld),
    .hw_rdat  (hw_rdat),
    .sw_cs    (sw_cs),
    .sw_ce    (sw_ce),
    .sw_we    (sw_we),
    .sw_add   (sw_add),
    .sw_wdat  (sw_wdat),
    .sw_rdat  (sw_rdat),
    .grant    (grant),
    .yield    (yield),
    .mem_cs   (mem_cs),
    .mem_ce   (mem_ce),
    .mem_we   (mem_we),
    .mem_add  (mem_add),
    .mem_wdat (mem_wdat),
    .mem_rdat (mem_rdat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  int         m_ptr, m_cnt, m_sel;
  bit         m_done, m_hold;
  logic [1:0] m_rvld;

  logic        e_grant, e_cs, e_ce, e_we;
  logic [1:0]  e_hw, e_rvld;
  logic [4:0]  e_add;
  logic [63:0] e_wdat;

  logic [1:0] rr_exp [4];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_cnt  = 0;
    m_done = 0;
    m_hold = 0;
    m_rvld = '0;
  endtask

  task automatic model_eval();
    bit swr;
    int j;
    m_sel   = -1;
    e_grant = 0;
    e_hw    = '0;
    swr     = sw_cs && !m_done;
    if (rst_n) begin
      if (!m_hold && swr &&
          (yield || m_cnt == LIM || hw_req == 2'b00))
        e_grant = 1;
      else
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (m_sel < 0 && hw_req[j]) m_sel = j;
        end
      if (m_sel >= 0) e_hw[m_sel] = 1'b1;
    end
    e_cs = 0; e_ce = 0; e_we = 0;
    e_add = '0; e_wdat = '0;
    if (e_grant) begin
      e_cs = 1; e_ce = sw_ce; e_we = sw_we;
      e_add = sw_add; e_wdat = sw_wdat;
    end else if (m_sel >= 0) begin
      e_cs = 1;
      e_we = hw_we[m_sel];
      e_add = hw_addr[m_sel];
      e_wdat = hw_wdat[m_sel];
    end
    e_rvld = rst_n ? m_rvld : 2'b00;
  endtask

  task automatic model_update();
    bit swr;
    if (!rst_n) begin
      model_reset();
    end else begin
      swr = sw_cs && !m_done;
      m_rvld = '0;
      if (m_sel >= 0) begin
        if (!hw_we[m_sel]) m_rvld[m_sel] = 1'b1;
        m_ptr = (m_sel + 1) % N;
      end
      if (swr && !e_grant)
        m_cnt = (m_cnt < 7) ? m_cnt + 1 : 7;
      else
        m_cnt = 0;
      m_hold = e_grant;
      m_done = sw_cs && (m_done || e_grant);
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
    chk("hw_gnt",   64'(hw_gnt),   64'(e_hw));
    chk("grant",    64'(grant),    64'(e_grant));
    chk("hw_rvld",  64'(hw_rvld),  64'(e_rvld));
    chk("mem_cs",   64'(mem_cs),   64'(e_cs));
    chk("mem_ce",   64'(mem_ce),   64'(e_ce));
    chk("mem_we",   64'(mem_we),   64'(e_we));
    chk("mem_add",  64'(mem_add),  64'(e_add));
    chk("mem_wdat", mem_wdat,      e_wdat);
    chk("hw_rdat",  hw_rdat,       mem_rdat);
    chk("sw_rdat",  sw_rdat,       mem_rdat);
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    hw_req = '0; hw_we = '0;
    hw_addr = '0; hw_wdat = '0;
    sw_cs = 0; sw_ce = 0; sw_we = 0;
    sw_add = '0; sw_wdat = '0;
    yield = 0; mem_rdat = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    settle();
    chk("rst_cs", 64'(mem_cs), 64'(0));
    chk("rst_gnt", 64'(hw_gnt), 64'(0));
    adv();
    adv();
    rst_n = 1;
  endtask

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    idle();
    rst_n = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Round robin on a held 2'b11 request
    hw_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("rr_seq", 64'(hw_gnt), 64'(rr_exp[i]));
      adv();
    end

    // Starved software is forced in the 8th cycle
    do_reset();
    hw_req = 2'b11;
    sw_cs = 1;
    for (int c = 1; c <= 8; c++) begin
      settle();
      chk("starve_grant", 64'(grant), 64'(c == 8));
      adv();
    end
    settle();
    chk("hold_nogrant", 64'(grant), 64'(0));
    chk("hold_hw", 64'(|hw_gnt), 64'(1));
    adv();

    // Yield forces software ahead of hardware
    do_reset();
    sw_cs = 1; yield = 1; hw_req = 2'b01;
    settle();
    chk("yield_grant", 64'(grant), 64'(1));
    chk("yield_hw", 64'(hw_gnt), 64'(0));
    adv();

    // Hardware read from requester 1
    do_reset();
    hw_req = 2'b10;
    hw_addr[1] = 5'd5;
    settle();
    chk("rd_gnt", 64'(hw_gnt), 64'(2'b10));
    chk("rd_add", 64'(mem_add), 64'(5));
    adv();
    hw_req = 2'b00;
    mem_rdat = 64'hA5;
    settle();
    chk("rd_rvld", 64'(hw_rvld), 64'(2'b10));
    chk("rd_rdat", hw_rdat, 64'hA5);
    adv();

    // Software compare access
    do_reset();
    sw_cs = 1; sw_ce = 1; sw_add = 5'd3;
    settle();
    chk("cmp_grant", 64'(grant), 64'(1));
    chk("cmp_ce", 64'(mem_ce), 64'(1));
    chk("cmp_add", 64'(mem_add), 64'(3));
    adv();
    settle();
    chk("cmp_nogrant", 64'(grant), 64'(0));
    adv();

    // Reset right after a hardware read grant
    do_reset();
    hw_req = 2'b01;
    settle();
    chk("rr_rd_gnt", 64'(hw_gnt), 64'(2'b01));
    @(posedge clk);
    model_update();
    #1 rst_n = 0;
    model_reset();
    @(negedge clk);
    hw_req = 2'b00;
    settle();
    chk("rst_rvld", 64'(hw_rvld), 64'(0));
    chk("rst_mcs", 64'(mem_cs), 64'(0));
    chk("rst_mwe", 64'(mem_we), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    adv();
    rst_n = 1;
    settle();
    chk("post_rvld", 64'(hw_rvld), 64'(0));
    adv();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      hw_req = 2'($urandom);
      hw_we  = 2'($urandom);
      for (int r = 0; r < N; r++) begin
        hw_addr[r] = 5'($urandom);
        hw_wdat[r] = {$urandom, $urandom};
      end
      if ($urandom_range(3) == 0) sw_cs = ~sw_cs;
      sw_ce   = 1'($urandom);
      sw_we   = 1'($urandom);
      sw_add  = 5'($urandom);
      sw_wdat = {$urandom, $urandom};
      yield   = ($urandom_range(9) == 0);
      mem_rdat = {$urandom, $urandom};
      rst_n   = ($urandom_range(299) != 0);
      settle();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
